adc_word_deser: RTL
===================

Name: adc_word_deser

Overview:
- Serial-to-parallel front-end stage for the ADC LVDS interface, running in the DCO clock domain.
- Samples the serial FCO line and LANES serial data lines, finds the word boundary by bit-slipping until the captured FCO word equals FCO_PATTERN, then emits parallel words.
- Produces word_valid and a per-word FCO marker (fco_out), which feed align_monitor_fco's word_valid and fco_in inputs directly downstream.

Parameters:
- WORD_BITS, 16, serial bits per word; legal range 4..32.
- LANES, 2, number of serial data lanes.
- FCO_PATTERN, 16'hFF00, expected FCO word at the correct alignment, MSB first. All WORD_BITS rotations of it must be distinct.
- LOCK_COUNT, 4, consecutive matching words required to declare lock.
- MISS_LIMIT, 4, consecutive mismatching words in LOCKED that force a return to SEARCH.

Ports:
- dco_clk, in, 1: bit clock; SDR, one bit sampled per rising edge.
- rst, in, 1: asynchronous, active-high reset.
- fco_ser, in, 1: serial frame clock, sampled as data.
- din, in, LANES: serial data, one bit per lane.
- word_data, out, LANES*WORD_BITS: parallel words; lane i occupies bits [i*WORD_BITS +: WORD_BITS], MSB = first bit received.
- word_valid, out, 1: one-cycle strobe, word_data valid.
- fco_out, out, 1: one-cycle pulse coincident with word_valid when that word's FCO capture equals FCO_PATTERN.
- locked, out, 1: high in LOCKED state.
- slip_cnt, out, 8: total bitslips since reset, saturating at 255.

Behaviour:
- Reset (asynchronous, takes effect immediately): every output is 0, shift registers and counters are 0, state is SEARCH. A reset mid-operation has the same effect in the same cycle.
- Shifting: every cycle, fco_ser and each din bit shift into WORD_BITS-wide shift registers, with the new bit entering the LSB.
- Bit counter (bcnt): counts 0..WORD_BITS-1 and increments every cycle unless a slip is pending.
- Boundary: the cycle after the sample taken at bcnt==WORD_BITS-1 is a boundary. At a boundary:
  - word_data and the FCO capture register load from the shift registers.
  - A compare is evaluated on the FCO capture.
  - Latency is 1 cycle from the last bit sampled to word_valid.
- Slip: holds bcnt for exactly one cycle, so the next boundary moves 1 bit later (WORD_BITS+1 cycles apart). slip_cnt increments per slip, saturating at 255.
- State machine (transitions evaluated on boundary cycles only):
  - SEARCH:
    - match -> CHECK, match count = 1.
    - mismatch -> stay in SEARCH, slip.
    - word_valid = 0 in this state.
  - CHECK:
    - match -> increment match count; on reaching LOCK_COUNT -> LOCKED.
    - mismatch -> SEARCH, slip, match count cleared.
    - word_valid = 0 in this state.
  - LOCKED:
    - locked = 1.
    - word_valid = 1 on every boundary; fco_out = compare result.
    - mismatch -> increment miss count; match -> clear miss count.
    - miss count reaching MISS_LIMIT -> SEARCH, locked = 0 from the next cycle, and a slip is applied on that same boundary.
- LOCK_COUNT=1: the first match goes directly SEARCH -> LOCKED.
- The word that completes lock is itself emitted: word_valid is asserted in the cycle that locked rises.
- Counter widths:
  - match counter: clog2(LOCK_COUNT+1) bits.
  - miss counter: clog2(MISS_LIMIT+1) bits.
  - bcnt: clog2(WORD_BITS) bits.
  - No wrap is permitted on any counter.
- slip_cnt clears only on rst; it persists across unlock and relock.

Decomposition:
- Package adc_fe_pkg holds:
  - enum align_state_t {SEARCH, CHECK, LOCKED}.
  - localparam defaults for WORD_BITS and FCO_PATTERN.
  - function rotl_word(), used by the bench.
- Sub-module sipo_lane: a WORD_BITS shift register with a capture-on-boundary output. Instantiated LANES+1 times: one per data lane plus one for FCO.
- The FSM, counters and slip logic live in adc_word_deser.

Test Plan:
- Aligned stream (first FCO bit sampled at bcnt=0), lane0 carrying 16'hA5C3 every word -> no slips (slip_cnt=0).
  - locked rises at the 4th boundary (cycle 4*16 after reset release, 1-cycle latency included).
  - After that, word_valid pulses every 16 cycles, word_data[15:0]=16'hA5C3, fco_out=1.
- Stream boundary delayed 5 bits -> slip_cnt=5 and lock after 5 slipped boundaries plus 4 matches; word_data correct thereafter. Repeat with delay 15 -> slip_cnt=15.
- Locked, then 3 consecutive corrupted FCO words -> locked stays 1, fco_out=0 on those 3 words, slip_cnt unchanged; miss count clears on the next good word.
- Locked, then 4 corrupted FCO words -> locked falls the cycle after the 4th bad boundary and slip_cnt increments by 1. Clean stream resumes -> relock once alignment is recovered.
- rst asserted mid-LOCKED, between edges -> all outputs 0 immediately. After release, relock with slip_cnt restarting from 0.
- Pathological stream with 300 boundary shifts -> slip_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/adc_fe_pkg.sv
// Shared types and defaults for the ADC LVDS front-end (DCO clock domain).
package adc_fe_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    localparam int                         DEF_WORD_BITS   = 16;
    localparam logic [DEF_WORD_BITS-1:0]   DEF_FCO_PATTERN = 16'hFF00;

    // Rotate the low 'bits' bits of w left by n positions.
    function automatic logic [31:0] rotl_word(input logic [31:0] w, input int n, input int bits);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
        r    = w & mask;
        for (int i = 0; i < n; i++) begin
            r = ((r << 1) | (r >> (bits - 1))) & mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_lane.sv
// One serial lane: shifts a bit in on every dco_clk edge (new bit at the LSB)
// and captures the completed word when capture is high.
module sipo_lane
    import adc_fe_pkg::*;
#(
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic                 dco_clk,
    input  logic                 rst,
    input  logic                 sdin,
    input  logic                 capture,
    output logic [WORD_BITS-1:0] word_next,
    output logic [WORD_BITS-1:0] word_cap
);

    // The oldest bit is only consumed at capture time, so history holds WORD_BITS-1 bits.
    logic [WORD_BITS-2:0] hist;

    assign word_next = {hist, sdin};

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            word_cap <= '0;
        end else begin
            hist <= word_next[WORD_BITS-2:0];
            if (capture) begin
                word_cap <= word_next;
            end
        end
    end

endmodule

// File: rtl/adc_word_deser.sv
// Serial-to-parallel ADC front-end: bit-slips until the FCO word matches
// FCO_PATTERN, then emits one parallel word per frame with an FCO marker.
module adc_word_deser
    import adc_fe_pkg::*;
#(
    parameter int                   WORD_BITS   = DEF_WORD_BITS,
    parameter int                   LANES       = 2,
    parameter logic [WORD_BITS-1:0] FCO_PATTERN = DEF_FCO_PATTERN,
    parameter int                   LOCK_COUNT  = 4,
    parameter int                   MISS_LIMIT  = 4
) (
    input  logic                       dco_clk,
    input  logic                       rst,
    input  logic                       fco_ser,
    input  logic [LANES-1:0]           din,
    output logic [LANES*WORD_BITS-1:0] word_data,
    output logic                       word_valid,
    output logic                       fco_out,
    output logic                       locked,
    output logic [7:0]                 slip_cnt,
    output align_state_t               dbg_state,
    output logic [WORD_BITS-1:0]       fco_word
);

    localparam int BCNT_W = $clog2(WORD_BITS);
    localparam int MCNT_W = $clog2(LOCK_COUNT + 1);
    localparam int XCNT_W = $clog2(MISS_LIMIT + 1);

    align_state_t                state, state_d;
    logic [BCNT_W-1:0]           bcnt;
    logic                        slip_pend;
    logic [MCNT_W-1:0]           match_cnt, match_d;
    logic [XCNT_W-1:0]           miss_cnt, miss_d;
    logic                        last_bit;
    logic                        match;
    logic                        slip_req;
    logic                        emit;
    logic [WORD_BITS-1:0]        fco_next;
    logic [LANES*WORD_BITS-1:0]  data_next_unused;

    // Word completes on this edge; every decision below is taken on that edge
    // so outputs show up one cycle after the last bit is sampled.
    assign last_bit  = !slip_pend && (bcnt == BCNT_W'(WORD_BITS - 1));
    assign match     = (fco_next == FCO_PATTERN);
    assign locked    = (state == LOCKED);
    assign dbg_state = state;

    sipo_lane #(.WORD_BITS(WORD_BITS)) u_fco_lane (
        .dco_clk   (dco_clk),
        .rst       (rst),
        .sdin      (fco_ser),
        .capture   (last_bit),
        .word_next (fco_next),
        .word_cap  (fco_word)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sipo_lane #(.WORD_BITS(WORD_BITS)) u_data_lane (
            .dco_clk   (dco_clk),
            .rst       (rst),
            .sdin      (din[i]),
            .capture   (last_bit),
            .word_next (data_next_unused[i*WORD_BITS +: WORD_BITS]),
            .word_cap  (word_data[i*WORD_BITS +: WORD_BITS])
        );
    end

    always_comb begin
        state_d  = state;
        match_d  = match_cnt;
        miss_d   = miss_cnt;
        slip_req = 1'b0;
        emit     = 1'b0;
        if (last_bit) begin
            unique case (state)
                SEARCH: begin
                    if (!match) begin
                        slip_req = 1'b1;
                    end else if (LOCK_COUNT == 1) begin
                        state_d = LOCKED;
                        emit    = 1'b1;
                        match_d = '0;
                    end else begin
                        state_d = CHECK;
                        match_d = MCNT_W'(1);
                    end
                end
                CHECK: begin
                    if (!match) begin
                        state_d  = SEARCH;
                        slip_req = 1'b1;
                        match_d  = '0;
                    end else if (match_cnt == MCNT_W'(LOCK_COUNT - 1)) begin
                        // The word completing lock is emitted as well.
                        state_d = LOCKED;
                        emit    = 1'b1;
                        match_d = '0;
                    end else begin
                        match_d = match_cnt + MCNT_W'(1);
                    end
                end
                LOCKED: begin
                    emit = 1'b1;
                    if (match) begin
                        miss_d = '0;
                    end else if (miss_cnt == XCNT_W'(MISS_LIMIT - 1)) begin
                        state_d  = SEARCH;
                        slip_req = 1'b1;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_cnt + XCNT_W'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge dco_clk or posedge rst) begin
        if (rst) begin
            state      <= SEARCH;
            bcnt       <= '0;
            slip_pend  <= 1'b0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            word_valid <= 1'b0;
            fco_out    <= 1'b0;
            slip_cnt   <= '0;
        end else begin
            state      <= state_d;
            match_cnt  <= match_d;
            miss_cnt   <= miss_d;
            word_valid <= emit;
            fco_out    <= emit && match;
            if (slip_req && (slip_cnt != 8'hFF)) begin
                slip_cnt <= slip_cnt + 8'd1;
            end
            // A slip freezes bcnt at 0 for one extra cycle, pushing the next boundary one bit later.
            if (slip_pend) begin
                slip_pend <= 1'b0;
            end else if (last_bit) begin
                bcnt      <= '0;
                slip_pend <= slip_req;
            end else begin
                bcnt <= bcnt + BCNT_W'(1);
            end
        end
    end

endmodule
